// File: rtl/requant_pkg.sv
// Shared widths, reset activation range, packed FIFO entry and the clamp helper
// for the requantize output packer.
package requant_pkg;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;

  localparam logic signed [OUT_W-1:0] RESET_ACT_MIN = 8'h80;
  localparam logic signed [OUT_W-1:0] RESET_ACT_MAX = 8'h7F;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic [2:0]       count;
    logic [ACC_W-1:0] data;
  } word_t;

  // Lower bound first, then upper bound, so an inverted range yields hi.
  function automatic logic [OUT_W-1:0] clamp_act(input logic signed [ACC_W:0] sum,
                                                 input logic signed [OUT_W-1:0] lo,
                                                 input logic signed [OUT_W-1:0] hi);
    logic signed [ACC_W:0] lo_x, hi_x, t;
    lo_x = {{(ACC_W+1-OUT_W){lo[OUT_W-1]}}, lo};
    hi_x = {{(ACC_W+1-OUT_W){hi[OUT_W-1]}}, hi};
    t = (sum < lo_x) ? lo_x : sum;
    t = (t > hi_x) ? hi_x : t;
    return t[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/requant_output_packer_word_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low. Push and pop may coincide at any fill level.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 35,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/requant_output_packer.sv
// Zero-point add, activation clamp and little-endian int8 packing of rescaled
// accumulators, with a word FIFO absorbing readback backpressure.
module requant_output_packer
  import requant_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_offset,
  input  logic [OUT_W-1:0] cfg_act_min,
  input  logic [OUT_W-1:0] cfg_act_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [2:0]       out_count,
  output logic             busy
);
  localparam int STAGES = 2;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  logic [ACC_W-1:0]        offset;
  logic signed [OUT_W-1:0] act_min, act_max;
  logic [STAGES:1]         vld_pipe, last_pipe;
  logic signed [ACC_W:0]   s1_sum;
  logic [OUT_W-1:0]        s2_y;
  lane_t                   lane;
  logic [ACC_W-1:0]        word, word_next;
  logic                    accept, push, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             inflight;
  word_t                   push_word, head;

  // Every in-flight element is charged a full FIFO slot, so a push never finds it full.
  assign inflight = {1'b0, fifo_count} + (CW+1)'(vld_pipe[1]) + (CW+1)'(vld_pipe[2]);
  assign in_ready = inflight < (CW+1)'(FIFO_DEPTH);
  assign accept   = in_valid && in_ready;
  assign busy     = (|vld_pipe) || (lane != '0) || !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset  <= '0;
      act_min <= RESET_ACT_MIN;
      act_max <= RESET_ACT_MAX;
    end else if (cfg_valid && !busy) begin
      offset  <= cfg_offset;
      act_min <= cfg_act_min;
      act_max <= cfg_act_max;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_sum    <= '0;
      s2_y      <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      last_pipe <= {last_pipe[STAGES-1:1], in_last};
      s1_sum    <= {in_data[ACC_W-1], in_data} + {offset[ACC_W-1], offset};
      s2_y      <= clamp_act(s1_sum, act_min, act_max);
    end
  end

  always_comb begin
    word_next = word;
    word_next[lane*OUT_W +: OUT_W] = s2_y;
  end

  assign push      = vld_pipe[STAGES] && ((lane == 2'd3) || last_pipe[STAGES]);
  assign push_word = '{count: {1'b0, lane} + 3'd1, data: word_next};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      word <= '0;
    end else if (vld_pipe[STAGES]) begin
      if (push) begin
        lane <= '0;
        word <= '0;
      end else begin
        lane <= lane + 1'b1;
        word <= word_next;
      end
    end
  end

  word_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(word_t)), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_word),
    .pop     (out_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.data  : '0;
  assign out_count = out_valid ? head.count : '0;
endmodule

// File: tb/tb_requant_output_packer.sv
// Table-driven directed vectors, hand-written backpressure/reset sequences and a
// randomized stream checked against a byte-queue reference model.
module tb_requant_output_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_offset = '0;
  logic [7:0]  cfg_act_min = '0, cfg_act_max = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  requant_output_packer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_offset(cfg_offset),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [34:0] got[$], exp_q[$];
  logic [7:0]  m_bytes[$];
  longint      m_off = 0, m_min = -128, m_max = 127;
  bit          rnd_ready = 0, hold_ready = 1, prev_stall = 0;
  logic [34:0] prev_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: clamp with plain integer arithmetic, bytes gathered in a queue.
  function automatic logic [7:0] ref_y(input logic [31:0] d);
    longint s = longint'(signed'(d)) + m_off;
    if (s < m_min) s = m_min;
    if (s > m_max) s = m_max;
    return 8'(s);
  endfunction

  task automatic model_acc(input logic [31:0] d, input bit l);
    logic [31:0] w = '0;
    m_bytes.push_back(ref_y(d));
    if (m_bytes.size() == 4 || l) begin
      for (int k = 0; k < m_bytes.size(); k++) w[8*k +: 8] = m_bytes[k];
      exp_q.push_back({3'(m_bytes.size()), w});
      m_bytes.delete();
    end
  endtask

  // Consumer: out_ready is set first, then the handshake about to happen is recorded.
  always @(negedge clk) begin
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    if (!reset) prev_stall = 0;
    else begin
      if (prev_stall) chk("hold_stable", {out_valid, out_count, out_data}, {1'b1, prev_word});
      if (out_valid && out_ready) got.push_back({out_count, out_data});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_count, out_data};
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic configure(input longint off, input longint mn, input longint mx);
    wait_idle();
    cfg_valid = 1; cfg_offset = 32'(off); cfg_act_min = 8'(mn); cfg_act_max = 8'(mx);
    @(negedge clk);
    cfg_valid = 0;
    m_off = off; m_min = mn; m_max = mx;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    model_acc(d, l);
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy || got.size() < exp_q.size()) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_words"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, got[i], exp_q[i]);
  endtask

  task automatic clear_q();
    got.delete(); exp_q.delete();
  endtask

  typedef struct {
    longint off, mn, mx;
    int n;
    logic [31:0] d[4];
    bit l[4];
    logic [31:0] ed;
    logic [2:0] ec;
  } vec_t;

  function automatic vec_t mk(input longint off, mn, mx, input int n,
                              input logic [31:0] d0, d1, d2, d3, input logic [3:0] lm,
                              input logic [31:0] ed, input logic [2:0] ec);
    vec_t v;
    v.off = off; v.mn = mn; v.mx = mx; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    for (int k = 0; k < 4; k++) v.l[k] = lm[k];
    v.ed = ed; v.ec = ec;
    return v;
  endfunction

  function automatic logic [31:0] bp_val(input int i);
    return 32'(i * 37 - 300);
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(10, -128, 127, 4, 1, 2, 3, 4, 4'b0000, 32'h0E0D0C0B, 4);
    vecs[1] = mk(0, -128, 127, 4, 200, -300, 32'h7FFFFFFF, 32'h80000000, 4'b0000, 32'h807F807F, 4);
    vecs[2] = mk(0, 0, 6, 4, -5, 3, 9, 6, 4'b0000, 32'h06060300, 4);
    vecs[3] = mk(0, -128, 127, 2, 5, 6, 0, 0, 4'b0010, 32'h00000605, 2);
    vecs[4] = mk(0, -128, 127, 4, 7, 8, 9, 10, 4'b0000, 32'h0A090807, 4);
    vecs[5] = mk(-100, -10, 20, 1, 50, 0, 0, 0, 4'b0001, 32'h000000F6, 1);
    vecs[6] = mk(0, 10, -5, 4, 0, 100, -100, 3, 4'b0000, 32'hFBFBFBFB, 4);
    vecs[7] = mk(32'h7FFFFFFF, -128, 127, 4, 32'h7FFFFFFF, 32'h80000000, 0, 32'h80000001,
                 4'b0000, 32'h007FFF7F, 4);

    reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1;
    @(negedge clk);

    foreach (vecs[r]) begin
      configure(vecs[r].off, vecs[r].mn, vecs[r].mx);
      for (int i = 0; i < vecs[r].n; i++) send(vecs[r].d[i], vecs[r].l[i]);
      if (r == 0) begin
        int n = 0;
        chk("lat_early", out_valid, 0);
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        chk("latency", n, 2);
      end
      drain("vec");
      chk("vec_data", got.size() > 0 ? got[0][31:0] : 32'hDEAD, vecs[r].ed);
      chk("vec_count", got.size() > 0 ? got[0][34:32] : 3'd0, vecs[r].ec);
      clear_q();
    end

    // Backpressure: 20 elements offered with the consumer stalled.
    begin
      int acc = 0;
      configure(0, -128, 127);
      hold_ready = 0;
      in_valid = 1; in_last = 0; in_data = bp_val(0);
      for (int c = 0; c < 80; c++) begin
        if (in_valid && in_ready) begin model_acc(in_data, 0); acc++; end
        @(negedge clk);
        in_data = bp_val(acc); in_valid = (acc < 20);
      end
      chk("bp_accepted", acc, 16);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head", {out_count, out_data}, exp_q[0]);
      chk("bp_no_pop", got.size(), 0);
      hold_ready = 1;
      while (acc < 20) begin send(bp_val(acc), 0); acc++; end
      drain("bp");
      clear_q();
    end

    // Config pulsed while busy must not take effect.
    configure(5, -128, 127);
    send(1, 0); send(2, 0);
    chk("busy_mid", busy, 1);
    cfg_valid = 1; cfg_offset = 100; cfg_act_min = 0; cfg_act_max = 0;
    @(negedge clk);
    cfg_valid = 0;
    send(3, 0); send(4, 0);
    drain("cfgbusy");
    chk("cfgbusy_data", got.size() > 0 ? got[0][31:0] : 32'hDEAD, 32'h09080706);
    clear_q();

    // Asynchronous reset with a queued word and a partial word in flight.
    hold_ready = 0;
    configure(3, -50, 50);
    for (int i = 0; i < 6; i++) send(i, 0);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_busy", busy, 0);
    clear_q(); m_bytes.delete();
    m_off = 0; m_min = -128; m_max = 127;
    @(negedge clk); @(negedge clk);
    reset = 1; hold_ready = 1;
    @(negedge clk);
    send(300, 0); send(-1, 0); send(2, 0); send(-200, 0);
    drain("postrst");
    chk("postrst_data", got.size() > 0 ? got[0][31:0] : 32'hDEAD, 32'h8002FF7F);
    clear_q();

    // Randomized batches with random consumer backpressure.
    rnd_ready = 1;
    for (int b = 0; b < 6; b++) begin
      configure(longint'($urandom_range(0, 400)) - 200,
                longint'($urandom_range(0, 255)) - 128,
                longint'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 400)) - 200);
        send(d, ($urandom_range(0, 4) == 0) || (i == 39));
        if ($urandom_range(0, 5) == 0) @(negedge clk);
      end
      drain("rnd");
      clear_q();
    end
    rnd_ready = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
